// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters: accept one op, drive the ALU, capture the result after SETTLE_CYCLES.
// Response valid SETTLE_CYCLES edges after accept; a stalled response blocks both request ports until consumed.
module alu_share_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter bit          ROUND_ROBIN   = 1'b1
) (
    input  logic       clk_i,
    input  logic       reset_ni,

    input  logic       req0_valid_i,
    output logic       req0_ready_o,
    input  logic [7:0] req0_data1_i,
    input  logic [7:0] req0_data2_i,
    input  logic [2:0] req0_select_i,
    output logic       rsp0_valid_o,
    input  logic       rsp0_ready_i,
    output logic [7:0] rsp0_result_o,
    output logic       rsp0_zero_o,

    input  logic       req1_valid_i,
    output logic       req1_ready_o,
    input  logic [7:0] req1_data1_i,
    input  logic [7:0] req1_data2_i,
    input  logic [2:0] req1_select_i,
    output logic       rsp1_valid_o,
    input  logic       rsp1_ready_i,
    output logic [7:0] rsp1_result_o,
    output logic       rsp1_zero_o,

    output logic [7:0] alu_data1_o,
    output logic [7:0] alu_data2_o,
    output logic [2:0] alu_select_o,
    input  logic [7:0] alu_result_i,
    input  logic       alu_zero_i,

    output logic       busy_o,
    output logic       grant_o
);
    localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam int          CNT_W      = $clog2(SETTLE_EFF + 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             grant_q, grant_d;
    logic [7:0]       alu_d1_q, alu_d1_d;
    logic [7:0]       alu_d2_q, alu_d2_d;
    logic [2:0]       alu_sel_q, alu_sel_d;
    logic [1:0]       rsp_vld_q, rsp_vld_d;
    logic [1:0][7:0]  rsp_res_q, rsp_res_d;
    logic [1:0]       rsp_zero_q, rsp_zero_d;

    logic [1:0]       req_vld;
    logic [1:0]       rsp_rdy;
    logic [1:0][7:0]  req_d1;
    logic [1:0][7:0]  req_d2;
    logic [1:0][2:0]  req_sel;
    logic [1:0]       ready;
    logic             win;

    assign req_vld = {req1_valid_i, req0_valid_i};
    assign rsp_rdy = {rsp1_ready_i, rsp0_ready_i};
    assign req_d1  = {req1_data1_i, req0_data1_i};
    assign req_d2  = {req1_data2_i, req0_data2_i};
    assign req_sel = {req1_select_i, req0_select_i};

    // On a tie, round-robin favours the port that was not served last.
    always_comb begin
        win   = 1'b0;
        ready = 2'b00;
        unique case (req_vld)
            2'b10:   win = 1'b1;
            2'b11:   win = ROUND_ROBIN ? ~last_q : 1'b0;
            default: win = 1'b0;
        endcase
        if (state_q == IDLE && reset_ni && req_vld != 2'b00) begin
            ready[win] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        grant_d    = grant_q;
        alu_d1_d   = alu_d1_q;
        alu_d2_d   = alu_d2_q;
        alu_sel_d  = alu_sel_q;
        rsp_vld_d  = rsp_vld_q;
        rsp_res_d  = rsp_res_q;
        rsp_zero_d = rsp_zero_q;
        unique case (state_q)
            IDLE: begin
                if ((ready & req_vld) != 2'b00) begin
                    alu_d1_d  = req_d1[win];
                    alu_d2_d  = req_d2[win];
                    alu_sel_d = req_sel[win];
                    grant_d   = win;
                    cnt_d     = CNT_W'(SETTLE_EFF);
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_res_d[grant_q]  = alu_result_i;
                    rsp_zero_d[grant_q] = alu_zero_i;
                    rsp_vld_d[grant_q]  = 1'b1;
                    state_d             = RESP;
                end
            end
            RESP: begin
                if (rsp_rdy[grant_q]) begin
                    rsp_vld_d[grant_q] = 1'b0;
                    last_d             = grant_q;
                    state_d            = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            grant_q    <= 1'b0;
            alu_d1_q   <= '0;
            alu_d2_q   <= '0;
            alu_sel_q  <= '0;
            rsp_vld_q  <= '0;
            rsp_res_q  <= '0;
            rsp_zero_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            alu_d1_q   <= alu_d1_d;
            alu_d2_q   <= alu_d2_d;
            alu_sel_q  <= alu_sel_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_res_q  <= rsp_res_d;
            rsp_zero_q <= rsp_zero_d;
        end
    end

    assign req0_ready_o  = ready[0];
    assign req1_ready_o  = ready[1];
    assign rsp0_valid_o  = rsp_vld_q[0];
    assign rsp1_valid_o  = rsp_vld_q[1];
    assign rsp0_result_o = rsp_res_q[0];
    assign rsp1_result_o = rsp_res_q[1];
    assign rsp0_zero_o   = rsp_zero_q[0];
    assign rsp1_zero_o   = rsp_zero_q[1];
    assign alu_data1_o   = alu_d1_q;
    assign alu_data2_o   = alu_d2_q;
    assign alu_select_o  = alu_sel_q;
    assign busy_o        = (state_q != IDLE);
    assign grant_o       = grant_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: DUT A (settle 2, round-robin) and DUT B (settle 0 -> 1, fixed priority) on shared stimulus.
module tb_alu_share_ctrl;
    localparam int SA = 2;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_vld;
    logic [1:0][7:0] req_d1;
    logic [1:0][7:0] req_d2;
    logic [1:0][2:0] req_sel;
    logic [1:0]      rsp_rdy;

    wire [1:0] a_rdy, a_rvld, a_z, b_rdy, b_rvld, b_z;
    wire [7:0] a_res0, a_res1, a_alu_d1, a_alu_d2, a_alu_res;
    wire [7:0] b_res0, b_res1, b_alu_d1, b_alu_d2, b_alu_res;
    wire [2:0] a_alu_sel, b_alu_sel;
    wire       a_alu_z, a_busy, a_grant, b_alu_z, b_busy, b_grant;

    int checks   = 0;
    int failures = 0;

    // Reference ALU: ZERO always reflects the 8-bit sum.
    function automatic logic [8:0] alu_f(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] sum;
        logic [7:0] r;
        sum = x + y;
        case (s)
            3'd1:    r = sum;
            3'd2:    r = x & y;
            3'd3:    r = x | y;
            default: r = x;
        endcase
        return {(sum == 8'h00), r};
    endfunction

    assign {a_alu_z, a_alu_res} = alu_f(a_alu_sel, a_alu_d1, a_alu_d2);
    assign {b_alu_z, b_alu_res} = alu_f(b_alu_sel, b_alu_d1, b_alu_d2);

    alu_share_ctrl #(.SETTLE_CYCLES(SA), .ROUND_ROBIN(1'b1)) dut_a (
        .clk_i(clk), .reset_ni(rst_n),
        .req0_valid_i(req_vld[0]), .req0_ready_o(a_rdy[0]), .req0_data1_i(req_d1[0]),
        .req0_data2_i(req_d2[0]), .req0_select_i(req_sel[0]),
        .rsp0_valid_o(a_rvld[0]), .rsp0_ready_i(rsp_rdy[0]), .rsp0_result_o(a_res0), .rsp0_zero_o(a_z[0]),
        .req1_valid_i(req_vld[1]), .req1_ready_o(a_rdy[1]), .req1_data1_i(req_d1[1]),
        .req1_data2_i(req_d2[1]), .req1_select_i(req_sel[1]),
        .rsp1_valid_o(a_rvld[1]), .rsp1_ready_i(rsp_rdy[1]), .rsp1_result_o(a_res1), .rsp1_zero_o(a_z[1]),
        .alu_data1_o(a_alu_d1), .alu_data2_o(a_alu_d2), .alu_select_o(a_alu_sel),
        .alu_result_i(a_alu_res), .alu_zero_i(a_alu_z),
        .busy_o(a_busy), .grant_o(a_grant)
    );

    alu_share_ctrl #(.SETTLE_CYCLES(0), .ROUND_ROBIN(1'b0)) dut_b (
        .clk_i(clk), .reset_ni(rst_n),
        .req0_valid_i(req_vld[0]), .req0_ready_o(b_rdy[0]), .req0_data1_i(req_d1[0]),
        .req0_data2_i(req_d2[0]), .req0_select_i(req_sel[0]),
        .rsp0_valid_o(b_rvld[0]), .rsp0_ready_i(rsp_rdy[0]), .rsp0_result_o(b_res0), .rsp0_zero_o(b_z[0]),
        .req1_valid_i(req_vld[1]), .req1_ready_o(b_rdy[1]), .req1_data1_i(req_d1[1]),
        .req1_data2_i(req_d2[1]), .req1_select_i(req_sel[1]),
        .rsp1_valid_o(b_rvld[1]), .rsp1_ready_i(rsp_rdy[1]), .rsp1_result_o(b_res1), .rsp1_zero_o(b_z[1]),
        .alu_data1_o(b_alu_d1), .alu_data2_o(b_alu_d2), .alu_select_o(b_alu_sel),
        .alu_result_i(b_alu_res), .alu_zero_i(b_alu_z),
        .busy_o(b_busy), .grant_o(b_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level model of DUT A: one op in flight, response due SA edges after accept.
    logic       m_active, m_port, m_last;
    int         m_acc, m_cyc;
    logic [1:0] m_vld, m_z;
    logic [7:0] m_res [2];
    logic [7:0] m_ad1, m_ad2;
    logic [2:0] m_asel;

    task automatic model_reset();
        m_active = 1'b0; m_port = 1'b0; m_last = 1'b1;
        m_vld = '0; m_z = '0; m_res[0] = '0; m_res[1] = '0;
        m_ad1 = '0; m_ad2 = '0; m_asel = '0;
    endtask

    function automatic logic [1:0] m_ready_f();
        if (m_active || !rst_n || req_vld == 2'b00) return 2'b00;
        if (req_vld == 2'b11) return (m_last == 1'b0) ? 2'b10 : 2'b01;
        return req_vld;
    endfunction

    task automatic model_step(input logic [1:0] er);
        logic [1:0] acc;
        acc = er & req_vld;
        if (!rst_n) begin
            model_reset();
        end else if (acc != 2'b00) begin
            m_active = 1'b1; m_port = acc[1]; m_acc = m_cyc;
            m_ad1 = req_d1[m_port]; m_ad2 = req_d2[m_port]; m_asel = req_sel[m_port];
        end else if (m_active && !m_vld[m_port] && (m_cyc - m_acc) == SA) begin
            {m_z[m_port], m_res[m_port]} = alu_f(m_asel, m_ad1, m_ad2);
            m_vld[m_port] = 1'b1;
        end else if (m_active && m_vld[m_port] && rsp_rdy[m_port]) begin
            m_vld[m_port] = 1'b0; m_last = m_port; m_active = 1'b0;
        end
        m_cyc++;
    endtask

    typedef struct packed {
        logic       p;
        logic [2:0] sel;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] res;
        logic       z;
    } vec_t;

    vec_t vecs [8];

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; req_vld = '0; rsp_rdy = '0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic do_op(input vec_t v, input string tag);
        int n;
        @(posedge clk); #1;
        req_vld = '0; req_vld[v.p] = 1'b1;
        req_d1[v.p] = v.d1; req_d2[v.p] = v.d2; req_sel[v.p] = v.sel;
        rsp_rdy = 2'b11;
        n = 0;
        @(negedge clk);
        while (!a_rdy[v.p] && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, a_rdy, 2'b01 << v.p);
        @(posedge clk); #1;
        req_vld = '0;
        @(negedge clk);
        chk({tag, "_busy"}, a_busy, 1);
        chk({tag, "_grant"}, a_grant, v.p);
        chk({tag, "_alu_d1"}, a_alu_d1, v.d1);
        chk({tag, "_alu_d2"}, a_alu_d2, v.d2);
        chk({tag, "_alu_sel"}, a_alu_sel, v.sel);
        chk({tag, "_vld_early0"}, a_rvld, 0);
        @(negedge clk);
        chk({tag, "_vld_early1"}, a_rvld, 0);
        @(negedge clk);
        chk({tag, "_vld"}, a_rvld, 2'b01 << v.p);
        chk({tag, "_result"}, v.p ? a_res1 : a_res0, v.res);
        chk({tag, "_zero"}, a_z[v.p], v.z);
        @(negedge clk);
        chk({tag, "_busy_drop"}, a_busy, 0);
        chk({tag, "_vld_drop"}, a_rvld, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, a_rdy, 0);
        chk({tag, "_rvld"}, a_rvld, 0);
        chk({tag, "_res0"}, a_res0, 0);
        chk({tag, "_res1"}, a_res1, 0);
        chk({tag, "_zero"}, a_z, 0);
        chk({tag, "_alu_d1"}, a_alu_d1, 0);
        chk({tag, "_alu_d2"}, a_alu_d2, 0);
        chk({tag, "_alu_sel"}, a_alu_sel, 0);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_grant"}, a_grant, 0);
        chk({tag, "_b_busy"}, b_busy, 0);
    endtask

    initial begin
        int n;
        int a_ord[$];
        int b_ord[$];
        int a_acc, a_v1, b_acc, b_v1, b_p1;
        logic [1:0] er;
        logic [1:0] acc;

        vecs[0] = '{1'b0, 3'd1, 8'h01, 8'h03, 8'h04, 1'b0};
        vecs[1] = '{1'b1, 3'd1, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{1'b0, 3'd0, 8'h5A, 8'h10, 8'h5A, 1'b0};
        vecs[3] = '{1'b1, 3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[4] = '{1'b0, 3'd3, 8'h80, 8'h01, 8'h81, 1'b0};
        vecs[5] = '{1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[6] = '{1'b0, 3'd2, 8'h0F, 8'hF1, 8'h01, 1'b1};
        vecs[7] = '{1'b1, 3'd1, 8'h7F, 8'h7F, 8'hFE, 1'b0};

        rst_n = 1'b0; req_vld = '0; req_d1 = '0; req_d2 = '0; req_sel = '0; rsp_rdy = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst_during");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_after");

        for (int i = 0; i < 8; i++) do_op(vecs[i], $sformatf("vec%0d", i));

        // Both ports request continuously: A alternates, B always serves port 0.
        do_reset();
        req_d1[0] = 8'hD5; req_d2[0] = 8'hEA; req_sel[0] = 3'd2;
        req_d1[1] = 8'h01; req_d2[1] = 8'h02; req_sel[1] = 3'd3;
        req_vld = 2'b11; rsp_rdy = 2'b11;
        a_acc = -1; a_v1 = -1; b_acc = -1; b_v1 = -1; b_p1 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (a_rdy[0]) a_ord.push_back(0); else if (a_rdy[1]) a_ord.push_back(1);
            if (b_rdy[0]) b_ord.push_back(0); else if (b_rdy[1]) begin b_ord.push_back(1); b_p1++; end
            if (a_rdy != 2'b00 && a_acc < 0) a_acc = c;
            if (a_rvld != 2'b00 && a_v1 < 0) a_v1 = c;
            if (b_rdy != 2'b00 && b_acc < 0) b_acc = c;
            if (b_rvld != 2'b00 && b_v1 < 0) b_v1 = c;
            if (a_rvld[0]) chk("rr_res0", a_res0, 8'hC0);
            if (a_rvld[1]) chk("rr_res1", a_res1, 8'h03);
            if (b_rvld[0]) begin chk("fp_res0", b_res0, 8'hC0); chk("fp_zero0", b_z[0], 0); end
            if (b_busy) chk("fp_grant", b_grant, 0);
        end
        @(posedge clk); #1;
        req_vld = '0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_order%0d", i), (i < a_ord.size()) ? a_ord[i] : 99, i % 2);
            chk($sformatf("fp_order%0d", i), (i < b_ord.size()) ? b_ord[i] : 99, 0);
        end
        chk("fp_port1_accepts", b_p1, 0);
        chk("fp_res1_untouched", b_res1, 0);
        chk("rr_latency", a_v1 - a_acc, SA + 1);
        chk("fp_latency_settle0", b_v1 - b_acc, 2);

        // Backpressure on port 0 holds off port 1.
        do_reset();
        req_d1[0] = 8'h20; req_d2[0] = 8'h22; req_sel[0] = 3'd1;
        req_d1[1] = 8'h0C; req_d2[1] = 8'h30; req_sel[1] = 3'd3;
        req_vld = 2'b11; rsp_rdy = 2'b10;
        n = 0; @(negedge clk);
        while (!a_rdy[0] && n < 20) begin @(negedge clk); n++; end
        chk("bp_first_ready", a_rdy, 2'b01);
        @(posedge clk); #1;
        req_vld[0] = 1'b0;
        n = 0; @(negedge clk);
        while (!a_rvld[0] && n < 20) begin @(negedge clk); n++; end
        chk("bp_rsp0_vld", a_rvld[0], 1);
        chk("bp_rsp0_res", a_res0, 8'h42);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_vld", a_rvld[0], 1);
            chk("bp_hold_res", a_res0, 8'h42);
            chk("bp_ready1_blocked", a_rdy[1], 0);
            chk("bp_rvld1", a_rvld[1], 0);
        end
        @(posedge clk); #1;
        rsp_rdy[0] = 1'b1;
        @(negedge clk);
        chk("bp_vld_before_hs", a_rvld[0], 1);
        @(negedge clk);
        chk("bp_vld_after_hs", a_rvld[0], 0);
        chk("bp_idle", a_busy, 0);
        chk("bp_ready1_now", a_rdy, 2'b10);
        @(posedge clk); #1;
        req_vld[1] = 1'b0;
        n = 0; @(negedge clk);
        while (!a_rvld[1] && n < 20) begin @(negedge clk); n++; end
        chk("bp_rsp1_vld", a_rvld[1], 1);
        chk("bp_rsp1_res", a_res1, 8'h3C);
        chk("bp_rsp1_zero", a_z[1], 0);
        chk("bp_res0_kept", a_res0, 8'h42);

        // Reset while in EXEC discards the operation.
        do_reset();
        req_d1[0] = 8'h10; req_d2[0] = 8'h10; req_sel[0] = 3'd1;
        req_vld = 2'b01; rsp_rdy = 2'b11;
        n = 0; @(negedge clk);
        while (!a_rdy[0] && n < 20) begin @(negedge clk); n++; end
        chk("mid_rst_ready", a_rdy, 2'b01);
        @(posedge clk); #1;
        req_vld = '0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_alu_d1", a_alu_d1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_no_rsp", a_rvld, 0);
        end
        do_op(vecs[0], "post_rst");

        // Randomized traffic against the transaction model.
        do_reset();
        model_reset();
        m_cyc = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            er = m_ready_f();
            if (rst_n) chk("rnd_ready", a_rdy, er);
            chk("rnd_rvld", a_rvld, m_vld);
            chk("rnd_busy", a_busy, m_active);
            if (m_active) chk("rnd_grant", a_grant, m_port);
            chk("rnd_res0", a_res0, m_res[0]);
            chk("rnd_res1", a_res1, m_res[1]);
            chk("rnd_zero", a_z, m_z);
            chk("rnd_alu", {a_alu_sel, a_alu_d1, a_alu_d2}, {m_asel, m_ad1, m_ad2});
            @(posedge clk);
            acc = er & req_vld;
            model_step(er);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (acc[p] && rst_n) req_vld[p] = 1'b0;
                if (!req_vld[p] && $urandom_range(0, 2) == 0) begin
                    req_vld[p] = 1'b1;
                    req_d1[p]  = 8'($urandom);
                    req_d2[p]  = 8'($urandom_range(0, 3) == 0 ? 0 - req_d1[p] : $urandom);
                    req_sel[p] = 3'($urandom_range(0, 3));
                end
            end
            rsp_rdy = 2'($urandom);
            rst_n = ($urandom_range(0, 199) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
